// File: rtl/pulse_track_gate_if.sv
// Pulse/ADC bundle between the pulse source side and the pulse_track_gate tracker.
// The master drives the pulse indication and samples; the slave (the tracker) drives the results.
interface pulse_track_gate_if #(
    parameter int unsigned DW = 12,
    parameter int unsigned CW = 24
);
    logic          en_in;
    logic [DW-1:0] ad_in;
    logic          gate;
    logic          locked;
    logic [DW-1:0] peak_val;
    logic [CW-1:0] peak_pos;
    logic          peak_vld;
    logic          lost;

    modport master (
        output en_in, ad_in,
        input  gate, locked, peak_val, peak_pos, peak_vld, lost
    );

    modport slave (
        input  en_in, ad_in,
        output gate, locked, peak_val, peak_pos, peak_vld, lost
    );
endinterface

// File: rtl/pulse_track_gate.sv
// Locks onto a periodic pulse train and then opens an acquisition gate at the end of each period.
// Inside the gate it captures the peak sample, and it trims the period so the peak stays centred.
module pulse_track_gate #(
    parameter int unsigned DW       = 12,
    parameter int unsigned CW       = 24,
    parameter int unsigned PERIOD   = 2_500_000,
    parameter int unsigned TOL      = 50,
    parameter int unsigned MIN_W    = 4,
    parameter int unsigned DELAY    = 750,
    parameter int unsigned GATE_LEN = 2000,
    parameter int unsigned TRIM     = 50,
    parameter int unsigned THRESH   = 150,
    parameter int unsigned MISS_MAX = 3
) (
    input logic              clk,
    input logic              rst,
    pulse_track_gate_if.slave bus
);
    localparam logic [CW-1:0] PerC      = CW'(PERIOD);
    localparam logic [CW-1:0] TolC      = CW'(TOL);
    localparam logic [CW-1:0] ArmMax    = CW'(PERIOD + TOL);
    localparam logic [CW-1:0] GateStart = CW'(PERIOD - GATE_LEN);
    localparam logic [CW-1:0] MidPos    = CW'(PERIOD - GATE_LEN / 2);
    localparam logic [CW-1:0] PerShort  = CW'(PERIOD - TRIM);
    localparam logic [CW-1:0] PerLong   = CW'(PERIOD + TRIM);
    localparam logic [CW-1:0] DelayC    = CW'(DELAY);
    localparam logic [CW-1:0] OneC      = CW'(1);
    localparam logic [7:0]    MinWC     = 8'(MIN_W);
    localparam logic [7:0]    MissMaxC  = 8'(MISS_MAX);
    localparam logic [DW-1:0] ThreshC   = DW'(THRESH);

    typedef enum logic [1:0] {StIdle, StArm, StDelay, StTrack} state_e;

    state_e        state_q, state_d;
    logic          en_q, en_d;
    logic [7:0]    run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] phase_q, phase_d;
    logic [CW-1:0] period_q, period_d;
    logic [DW-1:0] max_q, max_d;
    logic [CW-1:0] max_pos_q, max_pos_d;
    logic [DW-1:0] peak_val_q, peak_val_d;
    logic [CW-1:0] peak_pos_q, peak_pos_d;
    logic          peak_vld_q, peak_vld_d;
    logic          lost_q, lost_d;
    logic [7:0]    miss_q, miss_d;

    logic          qual_edge;
    logic [CW-1:0] dev;
    logic          in_win;
    logic          gate_w;
    logic          wrap;

    assign qual_edge = en_q && !bus.en_in && (run_q >= MinWC);
    // Ordered subtraction keeps |interval - PERIOD| from wrapping.
    assign dev       = (cnt_q >= PerC) ? (cnt_q - PerC) : (PerC - cnt_q);
    assign in_win    = (dev <= TolC);
    assign gate_w    = (state_q == StTrack) && (phase_q >= GateStart);
    assign wrap      = (phase_q == period_q - OneC);

    always_comb begin
        state_d    = state_q;
        en_d       = bus.en_in;
        run_d      = bus.en_in ? ((run_q == 8'hff) ? run_q : run_q + 8'd1) : 8'd0;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        period_d   = period_q;
        max_d      = max_q;
        max_pos_d  = max_pos_q;
        peak_val_d = peak_val_q;
        peak_pos_d = peak_pos_q;
        peak_vld_d = 1'b0;
        lost_d     = 1'b0;
        miss_d     = miss_q;

        // Running max folds in the current sample so the last gate cycle counts at the wrap.
        if (gate_w && phase_q == GateStart) begin
            max_d     = bus.ad_in;
            max_pos_d = phase_q;
        end else if (gate_w && bus.ad_in > max_q) begin
            max_d     = bus.ad_in;
            max_pos_d = phase_q;
        end

        case (state_q)
            StIdle: begin
                if (qual_edge) begin
                    state_d = StArm;
                    cnt_d   = OneC;
                end
            end
            StArm: begin
                if (qual_edge) begin
                    cnt_d = OneC;
                    if (in_win) state_d = StDelay;
                end else if (cnt_q > ArmMax) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + OneC;
                end
            end
            StDelay: begin
                if (cnt_q >= DelayC) begin
                    state_d  = StTrack;
                    cnt_d    = '0;
                    phase_d  = '0;
                    period_d = PerC;
                    miss_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + OneC;
                end
            end
            StTrack: begin
                if (wrap) begin
                    phase_d    = '0;
                    peak_val_d = max_d;
                    peak_pos_d = max_pos_d;
                    peak_vld_d = 1'b1;
                    if (max_pos_d < MidPos)      period_d = PerShort;
                    else if (max_pos_d > MidPos) period_d = PerLong;
                    else                         period_d = PerC;
                    if (max_d < ThreshC) begin
                        if (miss_q + 8'd1 >= MissMaxC) begin
                            lost_d  = 1'b1;
                            state_d = StIdle;
                            miss_d  = 8'd0;
                        end else begin
                            miss_d = miss_q + 8'd1;
                        end
                    end else begin
                        miss_d = 8'd0;
                    end
                end else begin
                    phase_d = phase_q + OneC;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            en_q       <= 1'b0;
            run_q      <= 8'd0;
            cnt_q      <= '0;
            phase_q    <= '0;
            period_q   <= PerC;
            max_q      <= '0;
            max_pos_q  <= '0;
            peak_val_q <= '0;
            peak_pos_q <= '0;
            peak_vld_q <= 1'b0;
            lost_q     <= 1'b0;
            miss_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            period_q   <= period_d;
            max_q      <= max_d;
            max_pos_q  <= max_pos_d;
            peak_val_q <= peak_val_d;
            peak_pos_q <= peak_pos_d;
            peak_vld_q <= peak_vld_d;
            lost_q     <= lost_d;
            miss_q     <= miss_d;
        end
    end

    assign bus.gate     = gate_w;
    assign bus.locked   = (state_q == StTrack);
    assign bus.peak_val = peak_val_q;
    assign bus.peak_pos = peak_pos_q;
    assign bus.peak_vld = peak_vld_q;
    assign bus.lost     = lost_q;
endmodule

// File: tb/tb_pulse_track_gate.sv
// Directed bench for pulse_track_gate: stimulus pushes expected peak reports into a queue,
// and a negedge monitor pops and compares them whenever peak_vld is seen.
module tb_pulse_track_gate;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        int val;
        int pos;
        int len;
        int lost;
    } exp_t;
    exp_t exp_q[$];

    pulse_track_gate_if #(.DW(12), .CW(24)) bus ();

    pulse_track_gate #(
        .DW(12), .CW(24), .PERIOD(1000), .TOL(5), .MIN_W(4), .DELAY(20),
        .GATE_LEN(100), .TRIM(5), .THRESH(150), .MISS_MAX(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns in the cycle where en_in has just dropped (the falling-edge cycle).
    task automatic pulse(input int w);
        bus.en_in = 1'b1;
        step(w);
        bus.en_in = 1'b0;
    endtask

    task automatic lock_check();
        step(20);
        check("delay_not_locked", int'(bus.locked), 0);
        step(1);
        check("locked_after_delay", int'(bus.locked), 1);
    endtask

    task automatic lock_seq();
        pulse(6);
        step(994);
        pulse(6);
        lock_check();
    endtask

    function automatic int sample(input int p, input int shape, input int pk_pos,
                                  input int pk_val, input int pk2);
        int d;
        if (p < 900) return 4095;
        if (shape == 1 || p == pk2) return pk_val;
        d = (p > pk_pos) ? p - pk_pos : pk_pos - p;
        return (d >= pk_val) ? 0 : pk_val - d;
    endfunction

    // Drives one tracking period starting at phase 0; ends at phase 0 of the next period.
    task automatic track_period(input int len, input int shape, input int pk_pos, input int pk_val,
                                input int pk2, input int e_val, input int e_pos, input int e_lost);
        int gcount;
        exp_t e;
        e.val = e_val;
        e.pos = e_pos;
        e.len = len;
        e.lost = e_lost;
        exp_q.push_back(e);
        gcount = 0;
        for (int p = 0; p < len; p++) begin
            bus.ad_in = 12'(sample(p, shape, pk_pos, pk_val, pk2));
            if (bus.gate) gcount++;
            step(1);
        end
        check("gate_cycles", gcount, len - 900);
    endtask

    // Monitor: compare each peak report with the oldest expectation.
    int   start_cyc = 0;
    logic locked_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.locked && !locked_prev) start_cyc = cyc;
        locked_prev = bus.locked;
        if (!rst && bus.peak_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_peak_vld", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("peak_val", int'(bus.peak_val), e.val);
                check("peak_pos", int'(bus.peak_pos), e.pos);
                check("period_len", cyc - start_cyc, e.len);
                check("lost_at_report", int'(bus.lost), e.lost);
                start_cyc = cyc;
            end
        end
    end

    initial begin
        int gcount;
        int lcount;
        bus.en_in = 1'b0;
        bus.ad_in = '0;
        rst = 1'b1;
        step(3);
        check("rst_gate", int'(bus.gate), 0);
        check("rst_locked", int'(bus.locked), 0);
        check("rst_peak_val", int'(bus.peak_val), 0);
        check("rst_peak_pos", int'(bus.peak_pos), 0);
        check("rst_peak_vld", int'(bus.peak_vld), 0);
        check("rst_lost", int'(bus.lost), 0);
        rst = 1'b0;
        step(2);

        // Too-narrow pulses never qualify.
        pulse(3);
        step(997);
        pulse(3);
        step(21);
        check("narrow_no_lock", int'(bus.locked), 0);
        step(10);

        // 990-cycle interval restarts the reference; the next 1000-cycle edge locks.
        pulse(6);
        step(984);
        pulse(6);
        step(21);
        check("short_interval_no_lock", int'(bus.locked), 0);
        step(973);
        pulse(6);
        lock_check();

        // Peak capture, period trimming, tie handling, then three weak windows.
        track_period(1000, 0, 930, 400, -1, 400, 930, 0);
        track_period(995,  0, 970, 400, -1, 400, 970, 0);
        track_period(1005, 0, 950, 300, 960, 300, 950, 0);
        track_period(1000, 1, 0,   100, -1, 100, 900, 0);
        track_period(995,  1, 0,   100, -1, 100, 900, 0);
        track_period(995,  1, 0,   100, -1, 100, 900, 1);
        gcount = 0;
        lcount = 0;
        for (int i = 0; i < 300; i++) begin
            bus.ad_in = 12'd4095;
            if (bus.gate) gcount++;
            if (bus.locked) lcount++;
            step(1);
        end
        check("gate_after_lost", gcount, 0);
        check("locked_after_lost", lcount, 0);

        // Relock, then reset mid-gate.
        lock_seq();
        track_period(1000, 0, 940, 500, -1, 500, 940, 0);
        for (int p = 0; p < 950; p++) begin
            bus.ad_in = (p >= 900) ? 12'd4000 : 12'd0;
            step(1);
        end
        bus.ad_in = 12'd4000;
        rst = 1'b1;
        step(1);
        check("midrst_gate", int'(bus.gate), 0);
        check("midrst_locked", int'(bus.locked), 0);
        check("midrst_peak_val", int'(bus.peak_val), 0);
        check("midrst_peak_pos", int'(bus.peak_pos), 0);
        check("midrst_peak_vld", int'(bus.peak_vld), 0);
        check("midrst_lost", int'(bus.lost), 0);
        rst = 1'b0;
        bus.ad_in = '0;
        step(3);
        pulse(6);
        step(30);
        check("single_edge_no_lock", int'(bus.locked), 0);
        lock_seq();
        track_period(1000, 0, 920, 200, -1, 200, 920, 0);
        step(5);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
